fmul_seq: RTL and testbench

- Iterative single-precision (binary32) floating-point multiplier; companion to the iterative divider in the FP arithmetic unit.
- Same req/x/y/rslt/flag operand conventions as the divider.
- Adds an explicit busy/valid handshake.
- Radix-4 Booth mantissa multiply over 13 cycles, then a normalize/round cycle. Latency is fixed for all operands, including special cases.

---
 rtl/fmul_seq_if.sv | 13 +
 rtl/fmul_seq.sv | 200 ++++++++++++++++++++
 tb/tb_fmul_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fmul_seq_if.sv
// Request/response bundle for the iterative binary32 multiplier.
interface fmul_seq_if;
  logic        req;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        valid;
  logic [31:0] rslt;
  logic [4:0]  flag;

  modport master (output req, x, y, input busy, valid, rslt, flag);
  modport slave  (input req, x, y, output busy, valid, rslt, flag);
endinterface

// File: rtl/fmul_seq.sv
// Iterative binary32 multiplier: radix-4 Booth over ITER cycles, then one
// normalize/round cycle; fixed LAT-cycle latency including special operands.
module fmul_seq #(
  parameter int unsigned ITER = 13,
  parameter int unsigned LAT  = ITER + 2
) (
  input  logic       clk,
  input  logic       reset,
  fmul_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, valid_q;
  logic [31:0]    rslt_q;
  logic [4:0]     flag_q;

  logic [23:0]    a_q;
  logic [25:0]    mplr_q, mplr_d;
  logic           prev_q, prev_d;
  logic [49:0]    acc_q, acc_d;
  logic [9:0]     e_q;
  logic           sign_q;
  logic           spc_q, spc_d;
  logic [31:0]    spc_rslt_q, spc_rslt_d;
  logic [4:0]     spc_flag_q, spc_flag_d;

  // Operand classification at acceptance
  logic [7:0]  xe, ye;
  logic [22:0] xf, yf;
  logic        xs, ys, sgn;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;

  always_comb begin
    xe = bus.x[30:23];  xf = bus.x[22:0];  xs = bus.x[31];
    ye = bus.y[30:23];  yf = bus.y[22:0];  ys = bus.y[31];
    sgn    = xs ^ ys;
    x_zero = (xe == 8'h00);
    y_zero = (ye == 8'h00);
    x_inf  = (xe == 8'hff) && (xf == '0);
    y_inf  = (ye == 8'hff) && (yf == '0);
    x_nan  = (xe == 8'hff) && (xf != '0);
    y_nan  = (ye == 8'hff) && (yf != '0);
    x_snan = x_nan && !xf[22];
    y_snan = y_nan && !yf[22];

    spc_d      = 1'b1;
    spc_rslt_d = '0;
    spc_flag_d = '0;
    if (x_nan) begin
      spc_rslt_d = bus.x | 32'h0040_0000;
      spc_flag_d = {x_snan | y_snan, 4'b0000};
    end else if (y_nan) begin
      spc_rslt_d = bus.y | 32'h0040_0000;
      spc_flag_d = {y_snan, 4'b0000};
    end else if ((x_inf && y_zero) || (x_zero && y_inf)) begin
      spc_rslt_d = 32'hffc0_0000;
      spc_flag_d = 5'h10;
    end else if (x_inf || y_inf) begin
      spc_rslt_d = {sgn, 8'hff, 23'b0};
    end else if (x_zero || y_zero) begin
      spc_rslt_d = {sgn, 31'b0};
    end else begin
      spc_d = 1'b0;
    end
  end

  // Booth step: add the recoded multiple at bit 24, shift right by 2; the two
  // bits falling off the accumulator refill the top of the multiplier register.
  logic signed [26:0] a_ext, mult;
  logic [51:0]        sum;

  always_comb begin
    a_ext = {3'b000, a_q};
    case ({mplr_q[1:0], prev_q})
      3'b001, 3'b010: mult = a_ext;
      3'b011:         mult = a_ext <<< 1;
      3'b100:         mult = -(a_ext <<< 1);
      3'b101, 3'b110: mult = -a_ext;
      default:        mult = '0;
    endcase
    sum    = {{2{acc_q[49]}}, acc_q} + {mult[26], mult, 24'b0};
    acc_d  = sum[51:2];
    mplr_d = {sum[1:0], mplr_q[25:2]};
    prev_d = mplr_q[1];
  end

  // Normalize and round. Bits above p[47] and below mplr_q[24] are zero for a
  // completed product, so folding them into hi/sticky does not change results.
  logic [51:0] v;
  logic        hi, g, s, rnd;
  logic [22:0] mant;
  logic [9:0]  e1, ef;
  logic [32:0] rsum;
  logic [31:0] round_rslt;
  logic [4:0]  round_flag;

  always_comb begin
    v  = {acc_q, mplr_q[25:24]};
    hi = |v[51:47];
    if (hi) begin
      mant = v[46:24];
      g    = v[23];
      s    = (|v[22:0]) | (|mplr_q[23:0]);
    end else begin
      mant = v[45:23];
      g    = v[22];
      s    = (|v[21:0]) | (|mplr_q[23:0]);
    end
    e1   = e_q + {9'b0, hi};
    rnd  = g & (s | mant[0]);
    rsum = {e1, mant} + {32'b0, rnd};
    ef   = rsum[32:23];
    if ($signed(ef) >= 10'sd255) begin
      round_rslt = {sign_q, 8'hff, 23'b0};
      round_flag = 5'h05;
    end else if ($signed(ef) <= 10'sd0) begin
      round_rslt = {sign_q, 31'b0};
      round_flag = 5'h03;
    end else begin
      round_rslt = {sign_q, ef[7:0], rsum[22:0]};
      round_flag = {4'b0000, g | s};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      rslt_q     <= '0;
      flag_q     <= '0;
      a_q        <= '0;
      mplr_q     <= '0;
      prev_q     <= 1'b0;
      acc_q      <= '0;
      e_q        <= '0;
      sign_q     <= 1'b0;
      spc_q      <= 1'b0;
      spc_rslt_q <= '0;
      spc_flag_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            state_q    <= S_ITER;
            cnt_q      <= CW'(1);
            busy_q     <= 1'b1;
            a_q        <= {1'b1, xf};
            mplr_q     <= {2'b00, 1'b1, yf};
            prev_q     <= 1'b0;
            acc_q      <= '0;
            e_q        <= {2'b00, xe} + {2'b00, ye} - 10'd127;
            sign_q     <= sgn;
            spc_q      <= spc_d;
            spc_rslt_q <= spc_rslt_d;
            spc_flag_q <= spc_flag_d;
          end
        end
        S_ITER: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          prev_q <= prev_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= S_DONE;
          cnt_q   <= cnt_q + CW'(1);
          valid_q <= 1'b1;
          rslt_q  <= spc_q ? spc_rslt_q : round_rslt;
          flag_q  <= spc_q ? spc_flag_q : round_flag;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.rslt  = rslt_q;
  assign bus.flag  = flag_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Directed bench for fmul_seq: latency, busy window, rounding, specials,
// back-to-back requests and mid-operation reset.
module tb_fmul_seq;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  fmul_seq_if bus ();

  fmul_seq #(.ITER(13), .LAT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ef);
    int unsigned lat, nb;
    @(negedge clk);
    bus.req = 1'b1; bus.x = a; bus.y = b;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.x = $urandom; bus.y = $urandom;
    lat = 1; nb = 0;
    while (!bus.valid && lat < 40) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) nb++;
    check({tag, ".lat"},  lat, 15);
    check({tag, ".busy"}, nb, 15);
    check({tag, ".rslt"}, bus.rslt, er);
    check({tag, ".flag"}, {27'b0, bus.flag}, {27'b0, ef});
    @(posedge clk); #1;
    check({tag, ".idle"}, {30'b0, bus.valid, bus.busy}, 32'd0);
  endtask

  initial begin
    int unsigned lat, g, nv;
    reset = 1'b0; bus.req = 1'b0; bus.x = '0; bus.y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", {bus.valid, bus.busy, bus.flag, 25'b0}, 32'd0);
    check("rst.rslt", bus.rslt, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op("m1.5x2",   32'h3fc00000, 32'h40000000, 32'h40400000, 5'h00);
    run_op("sq1ulp",   32'h3f800001, 32'h3f800001, 32'h3f800002, 5'h01);
    run_op("neg6",     32'hc0000000, 32'h40400000, 32'hc0c00000, 5'h00);
    run_op("maxmant",  32'h3fffffff, 32'h3fffffff, 32'h407ffffe, 5'h01);
    run_op("rndup",    32'h3fc00001, 32'h3fc00000, 32'h40100001, 5'h01);
    run_op("tie_odd",  32'h3f800001, 32'h3fc00000, 32'h3fc00002, 5'h01);
    run_op("tie_even", 32'h3f800003, 32'h3fc00000, 32'h3fc00004, 5'h01);
    run_op("ovf",      32'h7f000000, 32'h40000000, 32'h7f800000, 5'h05);
    run_op("unf",      32'h00800000, 32'h3f000000, 32'h00000000, 5'h03);
    run_op("unf_neg",  32'h80800000, 32'h3f000000, 32'h80000000, 5'h03);
    run_op("infx0",    32'h7f800000, 32'h00000000, 32'hffc00000, 5'h10);
    run_op("0xinf",    32'h80000000, 32'h7f800000, 32'hffc00000, 5'h10);
    run_op("xsnan",    32'h7f800001, 32'h3f800000, 32'h7fc00001, 5'h10);
    run_op("yqnan",    32'h3f800000, 32'h7fc00000, 32'h7fc00000, 5'h00);
    run_op("ysnan",    32'h3f800000, 32'hff800001, 32'hffc00001, 5'h10);
    run_op("xq_ys",    32'h7fc00000, 32'h7f800001, 32'h7fc00000, 5'h10);
    run_op("ninf",     32'hff800000, 32'h40000000, 32'hff800000, 5'h00);
    run_op("denorm",   32'h00000001, 32'hc0000000, 32'h80000000, 5'h00);

    // Back-to-back: req held through busy; second operands applied after acceptance
    @(negedge clk);
    bus.req = 1'b1; bus.x = 32'h3fc00000; bus.y = 32'h40000000;
    @(posedge clk); #1;
    bus.x = 32'hc0000000; bus.y = 32'h40400000;
    lat = 1;
    while (!bus.valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.lat1", lat, 15);
    check("b2b.rslt1", bus.rslt, 32'h40400000);
    @(posedge clk); #1;
    check("b2b.pulse", {31'b0, bus.valid}, 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("b2b.acc2", {31'b0, bus.busy}, 32'd1);
    g = 2;
    while (!bus.valid && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check("b2b.gap", g, 16);
    check("b2b.rslt2", bus.rslt, 32'hc0c00000);
    @(posedge clk); #1;

    // Reset at cnt==7 aborts the operation
    @(negedge clk);
    bus.req = 1'b1; bus.x = 32'h40000000; bus.y = 32'h40000000;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("abort.out", {bus.valid, bus.busy, bus.flag, 25'b0}, 32'd0);
    check("abort.rslt", bus.rslt, 32'd0);
    @(negedge clk); reset = 1'b1;
    nv = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.valid) nv++;
    end
    check("abort.novalid", nv, 0);
    run_op("post_rst", 32'h40000000, 32'h40000000, 32'h40800000, 5'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
